hist_writer: RTL and testbench

Producer side of the histogram scratch memory that the CDF stage reads. It accumulates a 64-bin histogram over one tile of streamed pixels. When the tile is complete it flushes the bins, in order, into scratch memory. It then pulses cdf_start to hand the memory to the CDF stage and holds off new pixels until cdf_done returns.

---
 rtl/hist_writer_if.sv | 41 ++++
 rtl/hist_writer.sv | 181 ++++++++++++++++++
 tb/tb_hist_writer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : hist_writer_if
// Description : Bundles the pixel stream, scratch-memory write port and CDF
//               handshake of the histogram producer.
//               master : histogram producer (hist_writer)
//               slave  : pixel source / scratch memory / CDF stage side
// Ports       : hist_start_in, pixel_valid, pixel_in, cdf_done   (to master)
//               pixel_ready, scratch_wr_en, scratch_wr_addr,
//               scratch_wr_data, cdf_start, tile_count          (from master)
// Revision    : 1.0 - initial release
// ============================================================================
interface hist_writer_if #(
    parameter int PIX_W  = 8,
    parameter int BIN_AW = 6,
    parameter int CNT_W  = 16
);
    logic              hist_start_in;
    logic              pixel_valid;
    logic [PIX_W-1:0]  pixel_in;
    logic              pixel_ready;
    logic              scratch_wr_en;
    logic [BIN_AW-1:0] scratch_wr_addr;
    logic [CNT_W-1:0]  scratch_wr_data;
    logic              cdf_start;
    logic              cdf_done;
    logic [7:0]        tile_count;

    modport master (
        input  hist_start_in, pixel_valid, pixel_in, cdf_done,
        output pixel_ready, scratch_wr_en, scratch_wr_addr, scratch_wr_data,
               cdf_start, tile_count
    );

    modport slave (
        output hist_start_in, pixel_valid, pixel_in, cdf_done,
        input  pixel_ready, scratch_wr_en, scratch_wr_addr, scratch_wr_data,
               cdf_start, tile_count
    );
endinterface
`default_nettype wire

// File: rtl/hist_writer.sv
`default_nettype none
// ============================================================================
// Module      : hist_writer
// Description : Accumulates a NUM_BINS histogram over one tile of
//               TILE_PIXELS pixels, flushes the bins in order into scratch
//               memory, pulses cdf_start and waits for cdf_done before a new
//               tile may be started.
// Ports       : clk    - clock, all logic on posedge
//               reset  - synchronous, active-low
//               bus    - hist_writer_if.master (pixel stream, scratch write
//                        port, CDF handshake, tile counter)
// Revision    : 1.0 - initial release
// ============================================================================
module hist_writer #(
    parameter int PIX_W       = 8,
    parameter int NUM_BINS    = 64,
    parameter int BIN_AW      = 6,
    parameter int CNT_W       = 16,
    parameter int TILE_PIXELS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    hist_writer_if.master bus
);

    localparam int                c_pc_w     = $clog2(TILE_PIXELS + 1);
    localparam logic [c_pc_w-1:0] c_last_pix = c_pc_w'(TILE_PIXELS - 1);
    localparam logic [BIN_AW-1:0] c_last_bin = BIN_AW'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCUM     = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_START_CDF = 3'd3,
        ST_WAIT_CDF  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_flush;
    logic [BIN_AW-1:0]   w_bin_idx;
    logic                w_unused_pix;

    logic [CNT_W-1:0]    r_bins [NUM_BINS];
    logic [c_pc_w-1:0]   r_pix_cnt;
    logic [BIN_AW-1:0]   r_flush_addr;

    logic                r_pixel_ready;
    logic                r_wr_en;
    logic [BIN_AW-1:0]   r_wr_addr;
    logic [CNT_W-1:0]    r_wr_data;
    logic                r_cdf_start;
    logic [7:0]          r_tile_count;

    // Only the top BIN_AW bits select a bin; the rest of the pixel is dropped.
    assign w_bin_idx    = bus.pixel_in[PIX_W-1 -: BIN_AW];
    assign w_unused_pix = ^bus.pixel_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.hist_start_in) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_accept = bus.pixel_valid && r_pixel_ready;
                if (w_accept && (r_pix_cnt == c_last_pix)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (r_flush_addr == c_last_bin) begin
                    w_state_next = ST_START_CDF;
                end
            end
            ST_START_CDF: begin
                w_state_next = ST_WAIT_CDF;
            end
            ST_WAIT_CDF: begin
                // A simultaneous hist_start_in is deliberately not captured.
                if (bus.cdf_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel and flush-address counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix_cnt    <= '0;
            r_flush_addr <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.hist_start_in) begin
                r_pix_cnt <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + c_pc_w'(1);
            end
            // Held at zero outside FLUSH so every flush starts from bin 0.
            r_flush_addr <= w_flush ? (r_flush_addr + BIN_AW'(1)) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Bin storage: saturating increment on accept, clear-on-read on flush.
    // Accept and flush never coincide, so one port per edge suffices and
    // back-to-back hits on the same bin read the value written last edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                r_bins[k] <= '0;
            end
        end else if (w_accept) begin
            if (r_bins[w_bin_idx] != c_cnt_max) begin
                r_bins[w_bin_idx] <= r_bins[w_bin_idx] + CNT_W'(1);
            end
        end else if (w_flush) begin
            r_bins[r_flush_addr] <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. pixel_ready follows the next state so it is
    // already low in the cycle right after the last pixel is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pixel_ready <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_cdf_start   <= 1'b0;
            r_tile_count  <= '0;
        end else begin
            r_pixel_ready <= (w_state_next == ST_ACCUM);
            r_wr_en       <= w_flush;
            r_wr_addr     <= w_flush ? r_flush_addr : '0;
            r_wr_data     <= w_flush ? r_bins[r_flush_addr] : '0;
            r_cdf_start   <= (r_state == ST_START_CDF);
            if (r_state == ST_START_CDF) begin
                r_tile_count <= r_tile_count + 8'd1;
            end
        end
    end

    assign bus.pixel_ready     = r_pixel_ready;
    assign bus.scratch_wr_en   = r_wr_en;
    assign bus.scratch_wr_addr = r_wr_addr;
    assign bus.scratch_wr_data = r_wr_data;
    assign bus.cdf_start       = r_cdf_start;
    assign bus.tile_count      = r_tile_count;

endmodule
`default_nettype wire

// File: tb/tb_hist_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hist_writer
// Description : Self-checking bench for hist_writer. Two instances: one with
//               16-bit counts and one with 12-bit counts for saturation.
//               Expected histograms are built from the pixel list of each
//               tile (bin = pixel / 4, clamped to the count maximum).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_writer;

    localparam int TILE = 4096;
    localparam int NB   = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bench drive
    logic       sel;
    logic       hist_start;
    logic       valid;
    logic [7:0] pix_in;
    logic       done;

    hist_writer_if #(.PIX_W(8), .BIN_AW(6), .CNT_W(16)) ifa ();
    hist_writer_if #(.PIX_W(8), .BIN_AW(6), .CNT_W(12)) ifb ();

    hist_writer #(.PIX_W(8), .NUM_BINS(64), .BIN_AW(6), .CNT_W(16), .TILE_PIXELS(TILE))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    hist_writer #(.PIX_W(8), .NUM_BINS(64), .BIN_AW(6), .CNT_W(12), .TILE_PIXELS(TILE))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    assign ifa.hist_start_in = !sel && hist_start;
    assign ifa.pixel_valid   = !sel && valid;
    assign ifa.pixel_in      = pix_in;
    assign ifa.cdf_done      = !sel && done;
    assign ifb.hist_start_in = sel && hist_start;
    assign ifb.pixel_valid   = sel && valid;
    assign ifb.pixel_in      = pix_in;
    assign ifb.cdf_done      = sel && done;

    // selected instance's outputs
    logic        m_ready, m_wr_en, m_cdf;
    logic [5:0]  m_addr;
    logic [15:0] m_data;
    logic [7:0]  m_tiles;
    assign m_ready = sel ? ifb.pixel_ready : ifa.pixel_ready;
    assign m_wr_en = sel ? ifb.scratch_wr_en : ifa.scratch_wr_en;
    assign m_cdf   = sel ? ifb.cdf_start : ifa.cdf_start;
    assign m_addr  = sel ? ifb.scratch_wr_addr : ifa.scratch_wr_addr;
    assign m_data  = sel ? {4'b0, ifb.scratch_wr_data} : ifa.scratch_wr_data;
    assign m_tiles = sel ? ifb.tile_count : ifa.tile_count;

    // observation log
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int cs_q[$];
    int last_ready_cyc = -1;

    always @(negedge clk) begin
        if (m_wr_en) begin
            wq_addr.push_back(int'(m_addr));
            wq_data.push_back(int'(m_data));
            wq_cyc.push_back(cyc);
        end
        if (m_cdf) cs_q.push_back(cyc);
        if (m_ready) last_ready_cyc = cyc;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference model
    logic [7:0] pix [TILE];
    int         exp_bins [NB];

    task automatic build_expected(input int cntw);
        int maxc;
        maxc = (1 << cntw) - 1;
        for (int k = 0; k < NB; k++) exp_bins[k] = 0;
        for (int i = 0; i < TILE; i++) exp_bins[int'(pix[i]) / 4]++;
        for (int k = 0; k < NB; k++) if (exp_bins[k] > maxc) exp_bins[k] = maxc;
    endtask

    // Starts a tile and streams pix[] with random valid gaps.
    // Entered and left at #1 after a posedge. n_last = cycle of last accept.
    task automatic drive_tile(input int stall_pct, input int done_at, output int n_last);
        int i;
        int bad_ready;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); cs_q.delete();
        hist_start = 1'b1;
        @(posedge clk); #1;
        hist_start = 1'b0;
        i = 0;
        bad_ready = 0;
        n_last = -1;
        while (i < TILE) begin
            valid  = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            pix_in = pix[i];
            done   = (done_at >= 0) && (i == done_at);
            @(negedge clk);
            if (!m_ready) bad_ready++;
            if (valid) begin
                if (i == TILE - 1) n_last = cyc;
                i++;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        done  = 1'b0;
        check("ready_low_in_accum", bad_ready, 0);
    endtask

    task automatic check_flush(input int n_last, input int cntw, input int exp_tiles, input bit pulse_done);
        int a, d, c, s_obs, s_exp;
        build_expected(cntw);
        for (int t = 0; t < 120; t++) begin
            done = pulse_done && (t == 20);
            @(posedge clk); #1;
        end
        done = 1'b0;
        check("n_writes", wq_addr.size(), NB);
        s_obs = 0;
        s_exp = 0;
        for (int k = 0; k < NB; k++) begin
            a = (k < wq_addr.size()) ? wq_addr[k] : -1;
            d = (k < wq_data.size()) ? wq_data[k] : -1;
            c = (k < wq_cyc.size())  ? wq_cyc[k]  : -1;
            check("wr_addr", a, k);
            check("wr_data", d, exp_bins[k]);
            check("wr_cycle", c, n_last + 2 + k);
            s_obs += d;
            s_exp += exp_bins[k];
        end
        check("flush_sum", s_obs, s_exp);
        check("cdf_start_count", cs_q.size(), 1);
        check("cdf_start_cycle", (cs_q.size() > 0) ? cs_q[0] : -1, n_last + 66);
        check("ready_last_cycle", last_ready_cyc, n_last);
        check("tile_count", m_tiles, exp_tiles);
    endtask

    task automatic finish_cdf();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_last;
        int found;
        int n_before;
        sel = 1'b0; hist_start = 1'b0; valid = 1'b0; pix_in = 8'h00; done = 1'b0;
        reset = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_a", ifa.pixel_ready, 0);
        check("rst_wr_en_a", ifa.scratch_wr_en, 0);
        check("rst_wr_addr_a", ifa.scratch_wr_addr, 0);
        check("rst_wr_data_a", ifa.scratch_wr_data, 0);
        check("rst_cdf_a", ifa.cdf_start, 0);
        check("rst_tiles_a", ifa.tile_count, 0);
        check("rst_ready_b", ifb.pixel_ready, 0);
        check("rst_tiles_b", ifb.tile_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", last_ready_cyc, -1);

        // tile 1: ramp
        for (int i = 0; i < TILE; i++) pix[i] = 8'(i);
        drive_tile(0, -1, n_last);
        check_flush(n_last, 16, 1, 1'b0);

        // start in WAIT_CDF is ignored
        hist_start = 1'b1;
        @(posedge clk); #1;
        hist_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("wait_start_ignored", last_ready_cyc, n_last);
        check("wait_no_writes", wq_addr.size(), NB);
        // done together with start: return to IDLE only
        hist_start = 1'b1;
        done = 1'b1;
        @(posedge clk); #1;
        hist_start = 1'b0;
        done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("done_start_same_cycle", last_ready_cyc, n_last);

        // tile 2: random pixels, random stalls, cdf_done in ACCUM and FLUSH
        for (int i = 0; i < TILE; i++) pix[i] = 8'($urandom);
        drive_tile(40, 500, n_last);
        check_flush(n_last, 16, 2, 1'b1);
        finish_cdf();

        // tile 3: backpressure, constant 0x04
        for (int i = 0; i < TILE; i++) pix[i] = 8'h04;
        drive_tile(35, -1, n_last);
        check_flush(n_last, 16, 3, 1'b0);
        finish_cdf();

        // tile 4: reset in the middle of the flush
        for (int i = 0; i < TILE; i++) pix[i] = 8'($urandom);
        drive_tile(0, -1, n_last);
        found = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(negedge clk);
            if (m_wr_en && (m_addr == 6'd20)) found = 1;
        end
        check("rst_flush_addr20_seen", found, 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstf_ready", ifa.pixel_ready, 0);
        check("rstf_wr_en", ifa.scratch_wr_en, 0);
        check("rstf_wr_addr", ifa.scratch_wr_addr, 0);
        check("rstf_wr_data", ifa.scratch_wr_data, 0);
        check("rstf_cdf", ifa.cdf_start, 0);
        check("rstf_tiles", ifa.tile_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        n_before = wq_addr.size();
        check("rstf_writes_before", n_before, 21);
        repeat (80) @(posedge clk);
        #1;
        check("rstf_no_more_writes", wq_addr.size(), n_before);
        check("rstf_no_cdf_start", cs_q.size(), 0);
        check("rstf_ready_stays_low", last_ready_cyc, n_last);

        // tile 5: zeros after reset, bins start clean
        for (int i = 0; i < TILE; i++) pix[i] = 8'h00;
        drive_tile(0, -1, n_last);
        check_flush(n_last, 16, 1, 1'b0);
        finish_cdf();

        // 12-bit instance: saturation
        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < TILE; i++) pix[i] = 8'hFF;
        drive_tile(0, -1, n_last);
        check_flush(n_last, 12, 1, 1'b0);
        finish_cdf();

        // 4000 back-to-back same-bin pixels stay below the 12-bit limit
        for (int i = 0; i < TILE; i++) pix[i] = (i < 4000) ? 8'hFF : 8'h00;
        drive_tile(0, -1, n_last);
        check_flush(n_last, 12, 2, 1'b0);
        finish_cdf();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
